// File: rtl/out_display.sv
// out_display: converts an 8-bit CPU output value to BCD (double dabble) and scans it onto a 4-digit 7-segment display.
// Ports: i_clk/i_rst clock and sync reset; i_value/i_load/i_signed load a new value;
// o_seg segments (bit0=a..bit6=g), o_dig one-hot digit enable (ones,tens,hundreds,sign), o_busy conversion in progress.
module out_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_value,
  input  logic       i_load,
  input  logic       i_signed,
  output logic [6:0] o_seg,
  output logic [3:0] o_dig,
  output logic       o_busy
);
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t r_state, w_next;
  logic [7:0]  r_bin, r_pval, w_sv, w_mag;
  logic [11:0] r_bcd;
  logic [10:0] w_adj;
  logic [2:0]  r_cnt;
  logic        r_cneg, r_pv, r_ps, w_ss, w_sneg, w_take_in, w_start, w_tc;
  logic [3:0]  r_h, r_t, r_o;
  logic        r_neg;
  logic [15:0] r_div;
  logic [1:0]  r_idx, w_nidx;
  logic [6:0]  w_seg;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // A load in COMMIT beats the pending slot (last wins) and starts the next conversion directly.
  always_comb begin
    w_take_in = i_load && (r_state == IDLE || r_state == COMMIT);
    w_start   = w_take_in || (r_state == COMMIT && r_pv);
    w_sv      = w_take_in ? i_value : r_pval;
    w_ss      = w_take_in ? i_signed : r_ps;
    w_sneg    = w_ss && w_sv[7];
    w_mag     = w_sneg ? ~w_sv + 8'd1 : w_sv;
    // Hundreds never reaches 5 before the last shift, so it needs no correction.
    w_adj     = {r_bcd[10:8], add3(r_bcd[7:4]), add3(r_bcd[3:0])};
  end

  always_ff @(posedge i_clk)
    r_state <= i_rst ? IDLE : w_next;

  always_comb
    w_next = (r_state == IDLE) ? (i_load ? CONV : IDLE) :
             (r_state == CONV) ? ((r_cnt == 3'd7) ? COMMIT : CONV) :
             (w_start ? CONV : IDLE);

  always_comb
    o_busy = r_state != IDLE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pv   <= 1'b0;
      r_pval <= 8'd0;
      r_ps   <= 1'b0;
      r_bin  <= 8'd0;
      r_bcd  <= 12'd0;
      r_cnt  <= 3'd0;
      r_cneg <= 1'b0;
      r_h    <= 4'd0;
      r_t    <= 4'd0;
      r_o    <= 4'd0;
      r_neg  <= 1'b0;
    end else begin
      if (i_load && r_state == CONV) begin
        r_pv   <= 1'b1;
        r_pval <= i_value;
        r_ps   <= i_signed;
      end else if (r_state == COMMIT) begin
        r_pv <= 1'b0;
      end
      if (w_start) begin
        r_bin  <= w_mag;
        r_bcd  <= 12'd0;
        r_cnt  <= 3'd0;
        r_cneg <= w_sneg;
      end else if (r_state == CONV) begin
        r_bcd <= {w_adj, r_bin[7]};
        r_bin <= {r_bin[6:0], 1'b0};
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == COMMIT) begin
        r_h   <= r_bcd[11:8];
        r_t   <= r_bcd[7:4];
        r_o   <= r_bcd[3:0];
        r_neg <= r_cneg;
      end
    end
  end

  always_comb begin
    w_tc   = r_div == 16'(SCAN_DIV - 1);
    w_nidx = r_idx + {1'b0, w_tc};
    w_seg  = (w_nidx == 2'd0) ? enc(r_o) :
             (w_nidx == 2'd1) ? ((r_h == 4'd0 && r_t == 4'd0) ? 7'h00 : enc(r_t)) :
             (w_nidx == 2'd2) ? ((r_h == 4'd0) ? 7'h00 : enc(r_h)) :
             (r_neg ? 7'h40 : 7'h00);
  end

  // Segments are registered from the next digit index so o_seg and o_dig move on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= 16'd0;
      r_idx <= 2'd0;
      o_dig <= 4'b0001;
      o_seg <= 7'h3F;
    end else begin
      r_div <= w_tc ? 16'd0 : r_div + 16'd1;
      r_idx <= w_nidx;
      o_dig <= 4'b0001 << w_nidx;
      o_seg <= w_seg;
    end
  end
endmodule

// File: tb/tb_out_display.sv
// tb_out_display: randomized scoreboard bench for out_display against an arithmetic reference model.
module tb_out_display;
  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_load = 1'b0, i_signed = 1'b0;
  logic [7:0] i_value = 8'd0;
  logic [6:0] o_seg;
  logic [3:0] o_dig;
  logic       o_busy;

  out_display #(.SCAN_DIV(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_value(i_value), .i_load(i_load),
    .i_signed(i_signed), .o_seg(o_seg), .o_dig(o_dig), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [27:0] c; int blen;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, done_cnt = 0, target = 0;
  logic ignore = 1'b1;
  logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [7:0] ev [3];
  logic       es [3];
  int         eo [3];

  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", n, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected codes {sign, hundreds, tens, ones}, 7 bits each.
  function automatic logic [27:0] expect_codes(input logic [7:0] v, input logic s);
    int m, h, t, o;
    logic neg;
    neg = s && v[7];
    m = neg ? 256 - int'(v) : int'(v);
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    return {neg ? 7'h40 : 7'h00, h == 0 ? 7'h00 : segtab[h],
            (h == 0 && t == 0) ? 7'h00 : segtab[t], segtab[o]};
  endfunction

  task automatic collect(output logic [27:0] got, output logic [3:0] seen);
    got = '0;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (o_dig == (4'b0001 << d)) begin
          got[d*7 +: 7] = o_seg;
          seen[d] = 1'b1;
        end
    end
  endtask

  task automatic compare_display(input string tag, input logic [27:0] req);
    logic [27:0] got;
    logic [3:0] seen;
    collect(got, seen);
    chk({tag, "_digits_seen"}, int'(seen), 4'hF);
    for (int d = 0; d < 4; d++)
      chk($sformatf("%s_dig%0d", tag, d), int'(got[d*7 +: 7]), int'(req[d*7 +: 7]));
  endtask

  initial begin
    int bcnt = 0;
    logic pb = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_busy) bcnt++;
      else begin
        if (pb && !ignore) begin
          if (q.size() == 0) chk("unexpected_commit", 1, 0);
          else begin
            e = q.pop_front();
            chk("busy_len", bcnt, e.blen);
            @(negedge clk);
            compare_display("disp", e.c);
          end
          done_cnt++;
        end
        bcnt = 0;
      end
      pb = o_busy;
    end
  end

  task automatic wait_done;
    int n = 0;
    target++;
    while (done_cnt < target && n < 300) begin
      tick;
      n++;
    end
    if (done_cnt < target) begin
      chk("commit_timeout", done_cnt, target);
      done_cnt = target;
    end
  endtask

  // Loads landing during the busy window collapse into one follow-up conversion of the last one.
  task automatic trial(input logic [7:0] v0, input logic s0, input int n);
    exp_t e;
    int t = 0;
    e.c = (n > 0) ? expect_codes(ev[n-1], es[n-1]) : expect_codes(v0, s0);
    e.blen = (n > 0) ? 18 : 9;
    q.push_back(e);
    i_value = v0; i_signed = s0; i_load = 1'b1;
    tick;
    i_load = 1'b0;
    for (int j = 0; j < n; j++) begin
      repeat (eo[j] - t - 1) tick;
      i_value = ev[j]; i_signed = es[j]; i_load = 1'b1;
      tick;
      i_load = 1'b0;
      t = eo[j];
    end
    wait_done;
  endtask

  initial begin
    int hi;
    tick;
    tick;
    i_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_seg", int'(o_seg), 7'h3F);
      end
      chk($sformatf("scan_%0d", i), int'(o_dig), 1 << ((i / 4) % 4));
    end
    ignore = 1'b0;
    trial(8'hFF, 1'b0, 0);
    trial(8'hFF, 1'b1, 0);
    trial(8'h80, 1'b1, 0);
    trial(8'h00, 1'b0, 0);
    trial(8'h0A, 1'b0, 0);
    ev = '{8'h02, 8'h03, 8'h07}; es = '{1'b0, 1'b0, 1'b0}; eo = '{2, 5, 9};
    trial(8'h01, 1'b0, 3);
    ignore = 1'b1;
    i_value = 8'h99; i_signed = 1'b0; i_load = 1'b1;
    tick;
    i_load = 1'b0;
    repeat (3) tick;
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_dig", int'(o_dig), 4'b0001);
    chk("abort_seg", int'(o_seg), 7'h3F);
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_busy) hi++;
    end
    chk("abort_no_busy", hi, 0);
    compare_display("abort", expect_codes(8'h00, 1'b0));
    ignore = 1'b0;
    tick;
    for (int r = 0; r < 30; r++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int j = 0; j < 3; j++) begin
        ev[j] = 8'($urandom);
        es[j] = 1'($urandom);
        eo[j] = $urandom_range(3 * j + 1, 3 * j + 3);
      end
      trial(8'($urandom), 1'($urandom), n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 SCAN_DIV, default 1000, clock cycles each digit is held before the scan advances (legal range 2..65535).
REQ-002 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous and active-high.
REQ-004 i_value  input  8  value from the CPU output register.
REQ-005 i_load  input  1  one-cycle strobe: i_value is new; sampled on the rising edge.
REQ-006 i_signed  input  1  sampled with i_load; 1 = interpret i_value as two's complement.
REQ-007 o_seg  output  7  segment drive, active-high, bit0=a ... bit6=g, for the currently selected digit.
REQ-008 o_dig  output  4  one-hot digit enable, active-high; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = sign.
REQ-009 o_busy  output  1  high while a conversion or commit is in progress.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CONV and COMMIT; o_busy SHALL equal (state != IDLE).
REQ-011 In IDLE, i_load=1 at edge k SHALL capture i_value and i_signed and enter CONV.
REQ-012 In signed mode with value bit7=1, the block SHALL convert the 8-bit two's-complement magnitude (0x80 -> 128) and flag the result negative; otherwise it SHALL convert i_value unsigned and flag it non-negative.
REQ-013 CONV SHALL perform binary-to-BCD shift-add-3 (double dabble), one bit per cycle, over exactly 8 cycles (edges k+1..k+8), then enter COMMIT.
REQ-014 At edge k+9 (COMMIT), the hundreds, tens, ones and sign display registers SHALL update together; o_busy SHALL therefore be high for exactly 9 cycles per conversion.
REQ-015 Until COMMIT, the display SHALL keep showing the previous committed value, with no partial digits.
REQ-016 An i_load during CONV or COMMIT SHALL store value and mode in a one-deep pending slot; a later load SHALL overwrite the slot (last wins).
REQ-017 At COMMIT, if the pending slot is valid, the FSM SHALL go to CONV with the pending data, clear the slot, and keep o_busy high; otherwise it SHALL go to IDLE.
REQ-018 An i_load in the same cycle as COMMIT SHALL go to the pending slot and be converted next.
REQ-019 Leading-zero blanking: hundreds blank (0x00) if 0; tens blank if hundreds and tens are both 0; ones always shown.
REQ-020 Sign digit SHALL show '-' (0x40) when the value is negative, else blank (0x00).
REQ-021 Segment codes SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-022 Scan: a divider SHALL count 0..SCAN_DIV-1; at terminal count the digit index SHALL advance 0->1->2->3->0 (wrap), and o_dig and o_seg SHALL change on the same edge.
REQ-023 o_seg and o_dig SHALL be registered outputs with no combinational path from any input.
REQ-024 Scanning SHALL run independently of the FSM and SHALL NOT stall during conversion.

Reset
REQ-025 i_rst=1 at an edge SHALL set: state IDLE, o_busy 0, pending slot cleared, display registers to value 0 non-negative, divider 0, digit index 0, o_dig=0001, o_seg=3F.
REQ-026 Reset SHALL take priority over i_load and SHALL abort any conversion in progress; no commit of that conversion SHALL occur.

Verification
REQ-027 Unsigned load 0xFF, SCAN_DIV=4 -> o_busy high 9 cycles; scan shows ones 6D, tens 6D, hundreds 5B, sign 00.
REQ-028 Signed load 0xFF -> ones 06, tens 00, hundreds 00, sign 40; signed load 0x80 -> 7F, 5B, 06, 40.
REQ-029 Load 0x00 unsigned -> ones 3F, tens and hundreds 00; load 0x0A -> ones 3F, tens 06, hundreds 00.
REQ-030 Load 0x01, then 0x02, 0x03 and 0x07 during busy -> commits of 1 then 7 only; o_busy continuous for 18 cycles.
REQ-031 i_rst asserted at edge k+4 of a conversion of 0x99 -> next cycle o_busy 0, o_dig 0001, o_seg 3F; 153 is never displayed.
REQ-032 SCAN_DIV=4, with no loads -> o_dig sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles.
